// File: rtl/e203_pad_cond.sv
// e203_pad_cond: GPIO pad conditioning between raw IO buffers and the SoC.
//   - Input path: per-channel synchronizer chain, optional debounce filter,
//     one-cycle edge pulses and sticky interrupt pending bits.
//   - Output path: one-cycle registered drive value and enable (tristate = ~pad_o_oe).
// Optional feature macro: E203_PAD_DEBOUNCE_EN
//   defined   -> per-channel DB_W-bit debounce counters compared against db_limit
//   undefined -> no counters, db_limit ignored, stable follows the synchronizer
// SYNC_STAGES must be at least 2.
module e203_pad_cond #(
  parameter int                GPIO_W      = 32,
  parameter int                SYNC_STAGES = 2,
  parameter int                DB_W        = 16,
  parameter logic [GPIO_W-1:0] IN_RST_VAL  = {GPIO_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] pad_i_ival,
  input  logic [DB_W-1:0]   db_limit,
  input  logic [GPIO_W-1:0] rise_ie,
  input  logic [GPIO_W-1:0] fall_ie,
  input  logic [GPIO_W-1:0] pend_clr,
  input  logic [GPIO_W-1:0] core_o_oval,
  input  logic [GPIO_W-1:0] core_o_oe,
  output logic [GPIO_W-1:0] sync_ival,
  output logic [GPIO_W-1:0] rise_evt,
  output logic [GPIO_W-1:0] fall_evt,
  output logic [GPIO_W-1:0] pend,
  output logic              irq,
  output logic [GPIO_W-1:0] pad_o_oval,
  output logic [GPIO_W-1:0] pad_o_oe
);

  // Synchronizer chain; the last stage is the channel's synchronized value.
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] sync_w;

  logic [GPIO_W-1:0] stable_q, stable_d;
  logic [GPIO_W-1:0] rise_q, fall_q;
  logic [GPIO_W-1:0] pend_q, pend_d;
  logic [GPIO_W-1:0] oval_q, oe_q;

  assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef E203_PAD_DEBOUNCE_EN
  logic [DB_W-1:0] cnt_q [GPIO_W];
  logic [DB_W-1:0] cnt_d [GPIO_W];

  // Debounce: count consecutive mismatch cycles, accept once the count reaches db_limit.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    stable_d = stable_q;
    for (int i = 0; i < GPIO_W; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != stable_q[i]) begin
        if (cnt_q[i] >= db_limit) begin
          stable_d[i] = sync_w[i];
        end else if (cnt_q[i] != {DB_W{1'b1}}) begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  // Debounce counter state; a reset mid-count abandons the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GPIO_W; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < GPIO_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  // Without the filter, db_limit has no function; stable tracks sync every cycle.
  logic unused_db_limit;
  assign unused_db_limit = ^db_limit;
  assign stable_d        = sync_w;
`endif

  // Pending bits: a new event sets, pend_clr clears, set wins on collision.
  always_comb begin
    pend_d = (rise_q & rise_ie) | (fall_q & fall_ie) | (pend_q & ~pend_clr);
  end

  // All channel state: synchronizer, stable value, edge pulses, pending, pad drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchronizer array is ordinary flops and is reset like any other register,
      // so the pull-up level is seen from the first cycle and no spurious edge appears.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IN_RST_VAL;
      stable_q <= IN_RST_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      oval_q   <= '0;
      oe_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous-cycle value.
      sync_q[0] <= pad_i_ival;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      stable_q <= stable_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
      pend_q   <= pend_d;
      oval_q   <= core_o_oval;
      oe_q     <= core_o_oe;
    end
  end

  assign sync_ival  = stable_q;
  assign rise_evt   = rise_q;
  assign fall_evt   = fall_q;
  assign pend       = pend_q;
  assign irq        = |pend_q;
  assign pad_o_oval = oval_q;
  assign pad_o_oe   = oe_q;

endmodule

// File: tb/tb_e203_pad_cond.sv
// tb_e203_pad_cond: directed self-checking bench for e203_pad_cond.
// Expected latencies follow whichever build is compiled (E203_PAD_DEBOUNCE_EN or not).
module tb_e203_pad_cond;
  localparam int W   = 32;
  localparam int SS  = 2;
  localparam int DBW = 16;
`ifdef E203_PAD_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   pad_i_ival, rise_ie, fall_ie, pend_clr, core_o_oval, core_o_oe;
  logic [DBW-1:0] db_limit;
  logic [W-1:0]   sync_ival, rise_evt, fall_evt, pend, pad_o_oval, pad_o_oe;
  logic           irq;

  int n_checks = 0;
  int n_errors = 0;

  e203_pad_cond #(.GPIO_W(W), .SYNC_STAGES(SS), .DB_W(DBW)) dut (
    .clk(clk), .rst_n(rst_n), .pad_i_ival(pad_i_ival), .db_limit(db_limit),
    .rise_ie(rise_ie), .fall_ie(fall_ie), .pend_clr(pend_clr),
    .core_o_oval(core_o_oval), .core_o_oe(core_o_oe),
    .sync_ival(sync_ival), .rise_evt(rise_evt), .fall_evt(fall_evt),
    .pend(pend), .irq(irq), .pad_o_oval(pad_o_oval), .pad_o_oe(pad_o_oe)
  );

  always #5 clk = ~clk;

  // Pad-to-sync_ival latency in cycles for a given threshold.
  function automatic int lat(input int db);
    return DEB ? (SS + db + 1) : (SS + 1);
  endfunction

  // Advance n rising edges and settle just past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pad_i_ival = '1; db_limit = '0; rise_ie = '0; fall_ie = '0;
    pend_clr = '0; core_o_oval = 32'hFFFF_FFFF; core_o_oe = 32'h0000_00FF;
    tick(3);
    n_checks++; if (sync_ival !== '1) begin n_errors++; $display("FAIL reset_sync_ival got %h exp %h", sync_ival, 32'hFFFF_FFFF); end
    n_checks++; if ((rise_evt | fall_evt) !== '0) begin n_errors++; $display("FAIL reset_evt got %h/%h exp 0", rise_evt, fall_evt); end
    n_checks++; if (pend !== '0 || irq !== 1'b0) begin n_errors++; $display("FAIL reset_pend got %h irq %b exp 0", pend, irq); end
    n_checks++; if (pad_o_oe !== '0 || pad_o_oval !== '0) begin n_errors++; $display("FAIL reset_pad_o got oe %h oval %h exp 0", pad_o_oe, pad_o_oval); end
    rst_n = 1'b1; core_o_oe = '0; core_o_oval = '0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_checks++; if (sync_ival !== '1 || (rise_evt | fall_evt) !== '0)
        begin n_errors++; $display("FAIL post_reset_quiet k=%0d sync %h rise %h fall %h exp ones/0/0", k, sync_ival, rise_evt, fall_evt); end
    end
  endtask

  task automatic test_output_reg();
    core_o_oe = 32'h0000_00FF; core_o_oval = 32'h0000_00A5;
    #1;
    n_checks++; if (pad_o_oe !== '0) begin n_errors++; $display("FAIL out_before_edge got oe %h exp 0", pad_o_oe); end
    tick(1);
    n_checks++; if (pad_o_oe !== 32'h0000_00FF || pad_o_oval !== 32'h0000_00A5)
      begin n_errors++; $display("FAIL out_vec1 got oe %h oval %h exp 000000ff 000000a5", pad_o_oe, pad_o_oval); end
    core_o_oe = 32'hFFFF_0000; core_o_oval = 32'h1234_5678;
    tick(1);
    n_checks++; if (pad_o_oe !== 32'hFFFF_0000 || pad_o_oval !== 32'h1234_5678)
      begin n_errors++; $display("FAIL out_vec2 got oe %h oval %h exp ffff0000 12345678", pad_o_oe, pad_o_oval); end
    core_o_oe = '0; core_o_oval = '0;
    tick(1);
  endtask

  // pad[0] falls and is held with db_limit=3; fall event then pend/irq a cycle later.
  task automatic test_fall();
    int l;
    db_limit = 16'd3; fall_ie[0] = 1'b1;
    l = lat(3);
    pad_i_ival[0] = 1'b0;
    for (int k = 1; k <= l + 1; k++) begin
      tick(1);
      n_checks++; if (sync_ival[0] !== (k < l)) begin n_errors++; $display("FAIL fall_sync k=%0d got %b exp %b", k, sync_ival[0], k < l); end
      n_checks++; if (fall_evt[0] !== (k == l) || rise_evt[0] !== 1'b0) begin n_errors++; $display("FAIL fall_evt k=%0d got fall %b rise %b exp %b 0", k, fall_evt[0], rise_evt[0], k == l); end
      n_checks++; if (pend[0] !== (k > l) || irq !== (k > l)) begin n_errors++; $display("FAIL fall_pend k=%0d got %b irq %b exp %b", k, pend[0], irq, k > l); end
    end
    pend_clr[0] = 1'b1; tick(1); pend_clr[0] = 1'b0;
    n_checks++; if (pend[0] !== 1'b0 || irq !== 1'b0) begin n_errors++; $display("FAIL fall_clr got %b irq %b exp 0", pend[0], irq); end
    fall_ie[0] = 1'b0;
  endtask

  // pad[5] low for two cycles: filtered out with debounce, passed through without.
  task automatic test_glitch();
    logic es, ef, er;
    db_limit = 16'd3;
    pad_i_ival[5] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 2) pad_i_ival[5] = 1'b1;
      es = DEB ? 1'b1 : !(k == 3 || k == 4);
      ef = DEB ? 1'b0 : (k == 3);
      er = DEB ? 1'b0 : (k == 5);
      n_checks++; if (sync_ival[5] !== es || fall_evt[5] !== ef || rise_evt[5] !== er)
        begin n_errors++; $display("FAIL glitch k=%0d got sync %b fall %b rise %b exp %b %b %b", k, sync_ival[5], fall_evt[5], rise_evt[5], es, ef, er); end
    end
  endtask

  // pad[1] rises with db_limit=100.
  task automatic test_rise();
    int l;
    db_limit = 16'd0; pad_i_ival[1] = 1'b0;
    tick(lat(0) + 1);
    n_checks++; if (sync_ival[1] !== 1'b0) begin n_errors++; $display("FAIL rise_pre got %b exp 0", sync_ival[1]); end
    db_limit = 16'd100; pad_i_ival[1] = 1'b1;
    l = lat(100);
    tick(l - 1);
    n_checks++; if (sync_ival[1] !== 1'b0 || rise_evt[1] !== 1'b0) begin n_errors++; $display("FAIL rise_early got %b evt %b exp 0 0", sync_ival[1], rise_evt[1]); end
    tick(1);
    n_checks++; if (sync_ival[1] !== 1'b1 || rise_evt[1] !== 1'b1) begin n_errors++; $display("FAIL rise_at_lat got %b evt %b exp 1 1", sync_ival[1], rise_evt[1]); end
    tick(1);
    n_checks++; if (rise_evt[1] !== 1'b0 || irq !== 1'b0) begin n_errors++; $display("FAIL rise_one_cycle got evt %b irq %b exp 0 0", rise_evt[1], irq); end
  endtask

  // Set and clear colliding on pend[2]: set wins; then a lone clear clears.
  task automatic test_pend_race();
    db_limit = 16'd0; rise_ie[2] = 1'b1; fall_ie[2] = 1'b1;
    pad_i_ival[2] = 1'b0;
    tick(lat(0) + 1);
    n_checks++; if (pend[2] !== 1'b1 || irq !== 1'b1) begin n_errors++; $display("FAIL race_setup got %b irq %b exp 1 1", pend[2], irq); end
    pad_i_ival[2] = 1'b1;
    tick(lat(0));
    n_checks++; if (rise_evt[2] !== 1'b1) begin n_errors++; $display("FAIL race_rise_evt got %b exp 1", rise_evt[2]); end
    pend_clr[2] = 1'b1; tick(1); pend_clr[2] = 1'b0;
    n_checks++; if (pend[2] !== 1'b1) begin n_errors++; $display("FAIL race_set_wins got %b exp 1", pend[2]); end
    pend_clr[2] = 1'b1; tick(1); pend_clr[2] = 1'b0;
    n_checks++; if (pend[2] !== 1'b0 || irq !== 1'b0) begin n_errors++; $display("FAIL race_lone_clr got %b irq %b exp 0 0", pend[2], irq); end
    rise_ie[2] = 1'b0; fall_ie[2] = 1'b0;
  endtask

  // Lowering db_limit below a running count accepts on the next compare.
  task automatic test_db_change();
    if (DEB) begin
      db_limit = 16'd10; pad_i_ival[3] = 1'b0;
      tick(7);
      n_checks++; if (sync_ival[3] !== 1'b1) begin n_errors++; $display("FAIL dbchg_hold got %b exp 1", sync_ival[3]); end
      db_limit = 16'd2;
      tick(1);
      n_checks++; if (sync_ival[3] !== 1'b0 || fall_evt[3] !== 1'b1) begin n_errors++; $display("FAIL dbchg_accept got %b evt %b exp 0 1", sync_ival[3], fall_evt[3]); end
      pad_i_ival[3] = 1'b1;
      tick(lat(2) + 1);
    end
  endtask

  // Reset mid-count: no event, async return to pull-up state, quiet afterwards.
  task automatic test_reset_mid();
    db_limit = 16'd3; core_o_oe = 32'h0000_FFFF;
    pad_i_ival[4] = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (sync_ival !== '1 || pad_o_oe !== '0 || pend !== '0)
      begin n_errors++; $display("FAIL async_reset got sync %h oe %h pend %h exp ones 0 0", sync_ival, pad_o_oe, pend); end
    pad_i_ival = '1; core_o_oe = '0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      n_checks++; if (sync_ival !== '1 || (rise_evt | fall_evt) !== '0 || irq !== 1'b0)
        begin n_errors++; $display("FAIL reset_mid_quiet k=%0d sync %h rise %h fall %h irq %b", k, sync_ival, rise_evt, fall_evt, irq); end
    end
  endtask

  initial begin
    test_reset();
    test_output_reg();
    test_fall();
    test_glitch();
    test_rise();
    test_pend_race();
    test_db_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/e203_pad_cond.md
E203_PAD_COND -- requirements
Module: e203_pad_cond

Interface
REQ-001 Parameter GPIO_W, default 32: number of pad channels.
REQ-002 Parameter SYNC_STAGES, default 2: input synchronizer depth; values below 2 are illegal.
REQ-003 Parameter DB_W, default 16: debounce counter width.
REQ-004 Parameter IN_RST_VAL, default {GPIO_W{1'b1}}: reset value of the synchronizer chain and the stable state, matching the pad pull-ups.
REQ-005 clk  input  1  single clock for all state.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 pad_i_ival  input  GPIO_W  raw pad input values from the IO buffers, asynchronous to clk.
REQ-008 db_limit  input  DB_W  debounce threshold in cycles, shared by all channels.
REQ-009 rise_ie / fall_ie  input  GPIO_W each  per-channel rising/falling edge interrupt enables.
REQ-010 pend_clr  input  GPIO_W  per-channel pending clear, one-cycle pulse, write-1-to-clear.
REQ-011 core_o_oval / core_o_oe  input  GPIO_W each  output value and output enable from the SoC.
REQ-012 sync_ival  output  GPIO_W  conditioned (synchronized and debounced) input value to the SoC.
REQ-013 rise_evt / fall_evt  output  GPIO_W each  one-cycle edge pulses.
REQ-014 pend  output  GPIO_W  sticky interrupt pending bits.
REQ-015 irq  output  1  OR-reduction of pend.
REQ-016 pad_o_oval / pad_o_oe  output  GPIO_W each  registered drive value and enable to the IO buffers (tristate control = ~pad_o_oe).

Function
REQ-017 Each channel SHALL pass pad_i_ival through SYNC_STAGES flops; the last stage is sync[i].
REQ-018 Each channel SHALL hold a stable bit (driven on sync_ival) and a DB_W-bit counter cnt.
REQ-019 When sync==stable, cnt SHALL load 0 on the next edge; a glitch shorter than the threshold therefore restarts counting.
REQ-020 When sync!=stable and cnt>=db_limit, the next edge SHALL load stable<=sync and cnt<=0 (accept).
REQ-021 When sync!=stable and cnt<db_limit, the next edge SHALL increment cnt, saturating at all-ones.
REQ-022 An accepted change SHALL require sync to mismatch for db_limit+1 consecutive cycles; pad-to-sync_ival latency is SYNC_STAGES+db_limit+1 cycles.
REQ-023 With db_limit=0, latency SHALL be SYNC_STAGES+1 cycles.
REQ-024 If db_limit is changed mid-count, the new value SHALL take effect on the next compare; a count already above the new limit accepts immediately.
REQ-025 rise_evt[i] SHALL be registered and high for exactly one cycle, in the same cycle that sync_ival[i] first shows 1; fall_evt[i] likewise for 0.
REQ-026 pend[i] SHALL set on (rise_evt&rise_ie)|(fall_evt&fall_ie) and clear on pend_clr[i]; when set and clear coincide, set SHALL win.
REQ-027 irq SHALL be the combinational OR of the pend registers.
REQ-028 pad_o_oval and pad_o_oe SHALL equal core_o_oval and core_o_oe delayed by exactly one cycle.
REQ-029 Channels SHALL be fully independent; there is no cross-channel interaction except irq.

Reset
REQ-030 On rst_n low, the synchronizer chain and stable SHALL load IN_RST_VAL, and cnt, rise_evt, fall_evt, pend, pad_o_oval and pad_o_oe SHALL load 0, so that the pads are tristated.
REQ-031 Reset asserted mid-debounce SHALL abandon the count without producing an event; after deassertion no event SHALL be generated for a pad already at IN_RST_VAL.

Configuration
REQ-032 With macro E203_PAD_DEBOUNCE_EN defined, the debounce counters SHALL be implemented as specified above.
REQ-033 Without E203_PAD_DEBOUNCE_EN, no counters SHALL be built and db_limit SHALL be ignored; stable SHALL be loaded with sync every cycle, giving the db_limit=0 behaviour and latency.

Verification
REQ-034 Reset, SYNC_STAGES=2, pad_i_ival held at all-ones -> sync_ival=all-ones, no evt pulses, pend=0, pad_o_oe=0.
REQ-035 db_limit=3, pad[0] falls at cycle 0 and is held -> sync_ival[0]=0 and fall_evt[0] pulse at cycle 6; with fall_ie[0]=1, pend[0] and irq are set at cycle 7.
REQ-036 db_limit=3, pad[5] low for 2 cycles then high -> sync_ival[5] stays 1, with no events.
REQ-037 pend[2] set, then rise_evt[2] with rise_ie[2]=1 coinciding with pend_clr[2] -> pend[2] remains 1; a lone pend_clr[2] -> pend[2]=0 and irq=0.
REQ-038 core_o_oe=32'h0000_00FF, core_o_oval=32'hA5 at cycle n -> the same values appear on pad_o_oe/pad_o_oval at cycle n+1.
REQ-039 Build without E203_PAD_DEBOUNCE_EN, db_limit=100, pad[1] rises -> sync_ival[1]=1 after 3 cycles.
